msg_schedule: RTL and testbench
===============================

Name: msg_schedule

Overview:
- Message-word stage between the block memory read port and the hash round datapath.
- Collects the 16 32-bit words of one 512-bit chunk as they return from memory.
- Presents one schedule word W[t] per hash round, with a valid/advance handshake.
- Handles MD5 (permuted index), SHA-1 and SHA-256 (recurrence expansion) from a 16-entry circular buffer. The hash datapath consumes w_out; the control block supplies start, opcode and md5_idx.

Parameters:
- WORD_W, 32, width of a message word; only 32 is supported.
- DEPTH, 16, circular buffer entries; fixed at one chunk.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_en  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a new chunk (accepted in any state)
- opcode  in  2  00 MD5, 01 SHA-1, 10 SHA-256, 11 reserved; sampled on start
- load_valid  in  1  load_word carries the next chunk word
- load_word  in  32  message word, in chunk order 0..15
- md5_idx  in  4  MD5 word index for the current round (g)
- advance  in  1  consumer has taken w_out this cycle
- w_out  out  32  schedule word W[t], registered
- w_valid  out  1  w_out is valid
- round  out  7  index t of w_out
- busy  out  1  high in LOAD or EXPAND
- done  out  1  one-cycle pulse after the last word is consumed
- err  out  1  sticky: reserved opcode or load_valid outside LOAD; cleared by start

Behaviour:
- Reset (reset_en=0, asynchronous):
  - all outputs 0; buffer contents 0; state IDLE; load counter 0; opcode register 0.
- States: IDLE, LOAD, EXPAND, DONE.
- IDLE:
  - start with opcode 00/01/10 -> LOAD; latch opcode; clear load counter and err.
  - start with opcode 11 -> stay IDLE; set err.
- LOAD:
  - Each load_valid writes buf[cnt] and increments cnt (4-bit).
  - The 16th write (cnt=15) -> EXPAND next cycle; round=0, w_valid=1, w_out=W[0].
  - Latency from last load_valid to w_valid is 1 cycle.
- EXPAND:
  - w_out changes only on advance while w_valid=1.
  - On advance: round increments and the next word is registered the same edge, so w_valid stays high (one word per cycle at full rate).
  - advance=0 holds w_out, round and buffer.
  - MD5: W[t]=buf[md5_idx]; md5_idx is sampled on the edge that loads that word. The buffer is never overwritten. Last round is 63.
  - SHA-1: t<16 gives buf[t]. t>=16 gives rotl1(w[t-3]^w[t-8]^w[t-14]^w[t-16]), written back to buf[t mod 16]. Last round is 79.
  - SHA-256: t<16 gives buf[t]. t>=16 gives s1(w[t-2])+w[t-7]+s0(w[t-15])+w[t-16], mod 2^32, written to buf[t mod 16].
    - s0 = rotr7 ^ rotr18 ^ shr3
    - s1 = rotr17 ^ rotr19 ^ shr10
    - Last round is 63.
  - Buffer indices are (t-k) mod 16 via 4-bit wrap-around.
  - advance on the last round -> DONE; w_valid=0.
- DONE: done=1 for one cycle -> IDLE; busy=0.
- Illegal or simultaneous events:
  - start in LOAD/EXPAND/DONE aborts the current chunk: w_valid=0, cnt=0, new opcode latched -> LOAD. start wins over advance and load_valid in the same cycle.
  - load_valid in IDLE/EXPAND/DONE is ignored and sets err.
  - advance with w_valid=0 is ignored.
- busy = LOAD or EXPAND.

Optional Feature:
- Macro MSG_SCHEDULE_BSWAP_EN.
- Defined: when the latched opcode is 00 (MD5), load_word bytes are reversed before being written (little-endian words from big-endian memory). SHA words are never swapped.
- Undefined: all words are stored unmodified.

Test Plan:
- SHA-256 "abc" padded block (W0=0x61626380, W15=0x00000018), advance held 1 -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; done pulses 1 cycle after round 63 is consumed.
- SHA-1 "abc" block -> W16=0xC2C4C700, W79 matches the golden model; exactly 80 words are delivered.
- MD5, words buf[i]=i, md5_idx stepping 1,6,11,0 -> w_out 1,6,11,0; buffer unchanged after 64 rounds. With MSG_SCHEDULE_BSWAP_EN defined, load 0x11223344 -> 0x44332211.
- advance toggled pseudo-randomly -> w_out and round held on every cycle with advance=0; word sequence identical to the full-rate run.
- start asserted at round 20 with opcode 10 -> w_valid=0 next cycle, LOAD entered, new chunk produces a correct W[0].
- reset_en dropped mid-EXPAND, not clock-aligned -> outputs 0 immediately. Separately: opcode 11 on start -> err=1, state IDLE; load_valid in IDLE -> err=1.

Source files
------------

// File: rtl/msg_schedule_if.sv
// Handshake bundle between the control block, the message schedule stage and the hash round datapath.
// The master modport drives chunk loading and round advance; the slave modport returns schedule words.
interface msg_schedule_if #(
   parameter int WORD_W = 32
);
   logic              start;
   logic [1:0]        opcode;
   logic              load_valid;
   logic [WORD_W-1:0] load_word;
   logic [3:0]        md5_idx;
   logic              advance;
   logic [WORD_W-1:0] w_out;
   logic              w_valid;
   logic [6:0]        round;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, opcode, load_valid, load_word, md5_idx, advance,
      input  w_out, w_valid, round, busy, done, err
   );

   modport slave (
      input  start, opcode, load_valid, load_word, md5_idx, advance,
      output w_out, w_valid, round, busy, done, err
   );
endinterface

// File: rtl/msg_schedule.sv
// Message schedule stage: buffers one 512-bit chunk and serves W[t] for MD5, SHA-1 and SHA-256 rounds.
// Optional macro MSG_SCHEDULE_BSWAP_EN byte-reverses MD5 words as they are loaded.
module msg_schedule #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic          clk,
   input  logic          reset_en,
   msg_schedule_if.slave bus
);

   localparam logic [1:0] OP_MD5    = 2'b00;
   localparam logic [1:0] OP_SHA1   = 2'b01;
   localparam logic [1:0] OP_RSVD   = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXPAND,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        opcode_q, opcode_d;
   logic [WORD_W-1:0] buf_q [DEPTH];
   logic [WORD_W-1:0] w_out_q, w_out_d;
   logic              w_valid_q, w_valid_d;
   logic [6:0]        round_q, round_d;
   logic              err_q, err_d;

   logic              wr_en;
   logic [3:0]        wr_idx;
   logic [WORD_W-1:0] wr_data;

   logic [WORD_W-1:0] load_data;
   logic [WORD_W-1:0] first_word;
   logic [WORD_W-1:0] next_word;
   logic [WORD_W-1:0] sha1_word;
   logic [WORD_W-1:0] sha256_word;
   logic [6:0]        next_t;
   logic [6:0]        last_round;
   logic [3:0]        t4, idx_m2, idx_m3, idx_m7, idx_m8, idx_m14, idx_m15;

   function automatic logic [31:0] rotl1(input logic [31:0] x);
      return {x[30:0], x[31]};
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

`ifdef MSG_SCHEDULE_BSWAP_EN
   assign load_data = (opcode_q == OP_MD5) ?
                      {bus.load_word[7:0], bus.load_word[15:8], bus.load_word[23:16], bus.load_word[31:24]} :
                      bus.load_word;
`else
   assign load_data = bus.load_word;
`endif

   // The buffer always holds w[t-16..t-1], so every tap is a 4-bit wrap-around offset from t.
   assign next_t     = round_q + 7'd1;
   assign t4         = next_t[3:0];
   assign idx_m2     = t4 - 4'd2;
   assign idx_m3     = t4 - 4'd3;
   assign idx_m7     = t4 - 4'd7;
   assign idx_m8     = t4 - 4'd8;
   assign idx_m14    = t4 - 4'd14;
   assign idx_m15    = t4 - 4'd15;
   assign last_round = (opcode_q == OP_SHA1) ? 7'd79 : 7'd63;

   assign sha1_word   = rotl1(buf_q[idx_m3] ^ buf_q[idx_m8] ^ buf_q[idx_m14] ^ buf_q[t4]);
   assign sha256_word = sig1(buf_q[idx_m2]) + buf_q[idx_m7] + sig0(buf_q[idx_m15]) + buf_q[t4];

   always_comb begin
      first_word = buf_q[0];
      if (opcode_q == OP_MD5) begin
         first_word = (bus.md5_idx == cnt_q) ? load_data : buf_q[bus.md5_idx];
      end
   end

   always_comb begin
      next_word = buf_q[t4];
      if (opcode_q == OP_MD5) begin
         next_word = buf_q[bus.md5_idx];
      end else if (next_t >= 7'd16) begin
         next_word = (opcode_q == OP_SHA1) ? sha1_word : sha256_word;
      end
   end

   // start overrides everything else in the cycle; a reserved opcode parks the stage in IDLE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      opcode_d  = opcode_q;
      w_out_d   = w_out_q;
      w_valid_d = w_valid_q;
      round_d   = round_q;
      err_d     = err_q;
      wr_en     = 1'b0;
      wr_idx    = cnt_q;
      wr_data   = load_data;

      if (bus.start) begin
         w_valid_d = 1'b0;
         cnt_d     = 4'd0;
         round_d   = 7'd0;
         if (bus.opcode == OP_RSVD) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end else begin
            state_d  = LOAD;
            opcode_d = bus.opcode;
            err_d    = 1'b0;
         end
      end else begin
         if (bus.load_valid && (state_q != LOAD)) begin
            err_d = 1'b1;
         end
         case (state_q)
            IDLE: begin
            end
            LOAD: begin
               if (bus.load_valid) begin
                  wr_en = 1'b1;
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     state_d   = EXPAND;
                     w_valid_d = 1'b1;
                     round_d   = 7'd0;
                     w_out_d   = first_word;
                  end
               end
            end
            EXPAND: begin
               if (bus.advance && w_valid_q) begin
                  if (round_q == last_round) begin
                     state_d   = DONE;
                     w_valid_d = 1'b0;
                  end else begin
                     round_d = next_t;
                     w_out_d = next_word;
                     if ((opcode_q != OP_MD5) && (next_t >= 7'd16)) begin
                        wr_en   = 1'b1;
                        wr_idx  = t4;
                        wr_data = next_word;
                     end
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_en) begin
      if (!reset_en) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         opcode_q  <= 2'b00;
         w_out_q   <= '0;
         w_valid_q <= 1'b0;
         round_q   <= 7'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opcode_q  <= opcode_d;
         w_out_q   <= w_out_d;
         w_valid_q <= w_valid_d;
         round_q   <= round_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge reset_en) begin
      if (!reset_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else if (wr_en) begin
         buf_q[wr_idx] <= wr_data;
      end
   end

   assign bus.w_out   = w_out_q;
   assign bus.w_valid = w_valid_q;
   assign bus.round   = round_q;
   assign bus.busy    = (state_q == LOAD) || (state_q == EXPAND);
   assign bus.done    = (state_q == DONE);
   assign bus.err     = err_q;

endmodule

// File: tb/tb_msg_schedule.sv
// Randomized bench for msg_schedule: a chunk-level reference model computes the full W[] expansion
// and is compared against the DUT every cycle, with literal golden values pinning the model.
module tb_msg_schedule;

   logic clk;
   logic reset_en;

   msg_schedule_if #(.WORD_W(32)) bus ();

   msg_schedule #(.WORD_W(32), .DEPTH(16)) dut (
      .clk      (clk),
      .reset_en (reset_en),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef enum {M_IDLE, M_LOAD, M_EXPAND, M_DONE} mstate_t;
   mstate_t     mState;
   logic [1:0]  mOp;
   int          mCnt;
   int          mT;
   logic        mValid;
   logic [31:0] mCur;
   logic        mErr;
   logic [31:0] mM [16];
   logic [31:0] mW [80];

   logic [31:0] chunk [16];
   logic [31:0] capWords [80];
   int          consumed = 0;
   logic        lastValid = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straight textbook expansion over the whole 80-entry array, no circular buffer.
   task automatic expandModel();
      for (int t = 0; t < 80; t++) begin
         if (t < 16) begin
            mW[t] = mM[t];
         end else if (mOp == 2'b01) begin
            mW[t] = ror(mW[t-3] ^ mW[t-8] ^ mW[t-14] ^ mW[t-16], 31);
         end else if (mOp == 2'b10 && t < 64) begin
            mW[t] = (ror(mW[t-2], 17) ^ ror(mW[t-2], 19) ^ (mW[t-2] >> 10)) + mW[t-7]
                  + (ror(mW[t-15], 7) ^ ror(mW[t-15], 18) ^ (mW[t-15] >> 3)) + mW[t-16];
         end else begin
            mW[t] = 32'h0;
         end
      end
   endtask

   function automatic logic [31:0] modelWord(input int t, input logic [3:0] idx);
      if (mOp == 2'b00) return mM[idx];
      return mW[t];
   endfunction

   always @(posedge clk or negedge reset_en) begin
      if (!reset_en) begin
         mState = M_IDLE; mOp = 2'b00; mCnt = 0; mT = 0; mValid = 1'b0; mCur = 32'h0; mErr = 1'b0;
         for (int i = 0; i < 16; i++) mM[i] = 32'h0;
      end else if (bus.start) begin
         mValid = 1'b0; mCnt = 0; mT = 0;
         if (bus.opcode == 2'b11) begin
            mState = M_IDLE; mErr = 1'b1;
         end else begin
            mState = M_LOAD; mOp = bus.opcode; mErr = 1'b0;
         end
      end else begin
         if (bus.load_valid && mState != M_LOAD) mErr = 1'b1;
         case (mState)
            M_LOAD: if (bus.load_valid) begin
`ifdef MSG_SCHEDULE_BSWAP_EN
               mM[mCnt] = (mOp == 2'b00) ? {<<8{bus.load_word}} : bus.load_word;
`else
               mM[mCnt] = bus.load_word;
`endif
               mCnt++;
               if (mCnt == 16) begin
                  mCnt = 0;
                  expandModel();
                  mState = M_EXPAND; mT = 0; mValid = 1'b1;
                  mCur = modelWord(0, bus.md5_idx);
               end
            end
            M_EXPAND: if (bus.advance && mValid) begin
               if (mT == ((mOp == 2'b01) ? 79 : 63)) begin
                  mState = M_DONE; mValid = 1'b0;
               end else begin
                  mT++;
                  mCur = modelWord(mT, bus.md5_idx);
               end
            end
            M_DONE: mState = M_IDLE;
            default: ;
         endcase
      end
   end

   always @(posedge clk) begin
      #2;
      checkOutput("w_valid", 32'(bus.w_valid), 32'(mValid));
      checkOutput("busy", 32'(bus.busy), 32'(mState == M_LOAD || mState == M_EXPAND));
      checkOutput("done", 32'(bus.done), 32'(mState == M_DONE));
      checkOutput("err", 32'(bus.err), 32'(mErr));
      if (mValid) begin
         checkOutput("w_out", bus.w_out, mCur);
         checkOutput("round", 32'(bus.round), 32'(mT));
      end
      if (bus.start) begin
         consumed = 0;
         for (int i = 0; i < 80; i++) capWords[i] = 32'hDEADBEEF;
      end else if (lastValid && bus.advance) begin
         consumed++;
      end
      if (bus.w_valid && bus.round < 7'd80) capWords[bus.round] = bus.w_out;
      lastValid = bus.w_valid;
   end

   task automatic applyStimulus(input logic st, input logic [1:0] op, input logic lv,
                                input logic [31:0] lw, input logic [3:0] idx, input logic adv);
      bus.start = st; bus.opcode = op; bus.load_valid = lv;
      bus.load_word = lw; bus.md5_idx = idx; bus.advance = adv;
      @(negedge clk);
   endtask

   function automatic logic [3:0] pickIdx(input int mode, input int t);
      if (mode == 1) return 4'((5 * t + 1) % 16);
      if (mode == 2) return 4'd0;
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic runChunk(input logic [1:0] op, input bit doStart, input int advPct,
                           input int idxMode, input int gapPct, input int abortAt);
      int guard;
      logic adv;
      if (doStart) applyStimulus(1'b1, op, 1'b0, 32'h0, 4'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         while (int'($urandom_range(0, 99)) < gapPct)
            applyStimulus(1'b0, op, 1'b0, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         applyStimulus(1'b0, op, 1'b1, chunk[i], pickIdx(idxMode, 0), 1'b0);
      end
      guard = 0;
      while (mState != M_IDLE && guard < 1000) begin
         if (abortAt >= 0 && mState == M_EXPAND && mValid && mT == abortAt) begin
            applyStimulus(1'b1, 2'b10, 1'b1, $urandom, 4'($urandom_range(0, 15)), 1'b1);
            return;
         end
         adv = (int'($urandom_range(0, 99)) < advPct);
         applyStimulus(1'b0, op, 1'b0, $urandom, pickIdx(idxMode, mT + 1), adv);
         guard++;
      end
      if (guard >= 1000) checkOutput("chunk_timeout", 32'(guard), 32'd0);
   endtask

   task automatic loadAbc();
      for (int i = 0; i < 16; i++) chunk[i] = 32'h0;
      chunk[0]  = 32'h61626380;
      chunk[15] = 32'h00000018;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      reset_en = 1'b0;
      bus.start = 1'b0; bus.opcode = 2'b00; bus.load_valid = 1'b0;
      bus.load_word = 32'h0; bus.md5_idx = 4'd0; bus.advance = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_w_out", bus.w_out, 32'h0);
      checkOutput("rst_w_valid", 32'(bus.w_valid), 32'd0);
      checkOutput("rst_round", 32'(bus.round), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_err", 32'(bus.err), 32'd0);
      reset_en = 1'b1;
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 4'd0, 1'b0);

      $display("[TB] reserved opcode");
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 4'd0, 1'b0);
      checkOutput("rsvd_err", 32'(bus.err), 32'd1);
      checkOutput("rsvd_busy", 32'(bus.busy), 32'd0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 4'd0, 1'b0);

      $display("[TB] SHA-256 abc full rate");
      loadAbc();
      runChunk(2'b10, 1'b1, 100, 0, 0, -1);
      checkOutput("model256_w16", mW[16], 32'h61626380);
      checkOutput("model256_w63", mW[63], 32'h12B1EDEB);
      checkOutput("abc256_w16", capWords[16], 32'h61626380);
      checkOutput("abc256_w17", capWords[17], 32'h000F0000);
      checkOutput("abc256_w63", capWords[63], 32'h12B1EDEB);
      checkOutput("abc256_count", 32'(consumed), 32'd64);

      $display("[TB] SHA-1 abc full rate");
      loadAbc();
      runChunk(2'b01, 1'b1, 100, 0, 0, -1);
      checkOutput("model160_w16", mW[16], 32'hC2C4C700);
      checkOutput("abc160_w16", capWords[16], 32'hC2C4C700);
      checkOutput("abc160_w79", capWords[79], mW[79]);
      checkOutput("abc160_count", 32'(consumed), 32'd80);

      $display("[TB] MD5 stepping index");
      for (int i = 0; i < 16; i++) chunk[i] = 32'(i);
      runChunk(2'b00, 1'b1, 100, 1, 0, -1);
      checkOutput("md5_w0", capWords[0], 32'd1);
      checkOutput("md5_w1", capWords[1], 32'd6);
      checkOutput("md5_w2", capWords[2], 32'd11);
      checkOutput("md5_w3", capWords[3], 32'd0);
      checkOutput("md5_w63", capWords[63], 32'd12);

`ifdef MSG_SCHEDULE_BSWAP_EN
      $display("[TB] MD5 byte swap");
      for (int i = 0; i < 16; i++) chunk[i] = $urandom;
      chunk[0] = 32'h11223344;
      runChunk(2'b00, 1'b1, 100, 2, 0, -1);
      checkOutput("md5_bswap", capWords[0], 32'h44332211);
`endif

      $display("[TB] SHA-256 abc random advance");
      loadAbc();
      runChunk(2'b10, 1'b1, 50, 0, 0, -1);
      for (int t = 0; t < 64; t++) checkOutput("abc256_seq", capWords[t], mW[t]);

      $display("[TB] random chunks");
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 16; i++) chunk[i] = $urandom;
         runChunk(2'($urandom_range(0, 2)), 1'b1, 60, 0, 30, -1);
      end

      $display("[TB] abort at round 20");
      for (int i = 0; i < 16; i++) chunk[i] = $urandom;
      runChunk(2'b01, 1'b1, 100, 0, 0, 20);
      checkOutput("abort_w_valid", 32'(bus.w_valid), 32'd0);
      checkOutput("abort_busy", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 16; i++) chunk[i] = $urandom;
      runChunk(2'b10, 1'b0, 100, 0, 0, -1);
      checkOutput("abort_new_w0", capWords[0], chunk[0]);

      $display("[TB] async reset mid-expand");
      for (int i = 0; i < 16; i++) chunk[i] = $urandom;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 4'd0, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 2'b10, 1'b1, chunk[i], 4'd0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 4'd0, 1'b1);
      #3 reset_en = 1'b0;
      #1;
      checkOutput("arst_w_out", bus.w_out, 32'h0);
      checkOutput("arst_w_valid", 32'(bus.w_valid), 32'd0);
      checkOutput("arst_round", 32'(bus.round), 32'd0);
      checkOutput("arst_busy", 32'(bus.busy), 32'd0);
      checkOutput("arst_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      reset_en = 1'b1;
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 4'd0, 1'b0);

      $display("[TB] load_valid in IDLE");
      applyStimulus(1'b0, 2'b00, 1'b1, $urandom, 4'd0, 1'b0);
      checkOutput("idle_load_err", 32'(bus.err), 32'd1);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 4'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
